// File: rtl/pifo_cmd_scheduler.sv
// Command ingress for the PIFO I/O port: in-order command queue feeding an issue FSM that
// retries rejected commands after a fixed backoff and drops them after MAX_RETRY failures.
module pifo_cmd_scheduler #(
    parameter int unsigned PTW           = 16,
    parameter int unsigned MTW           = 0,
    parameter int unsigned TREE_NUM      = 4,
    parameter int unsigned TREE_NUM_BITS = $clog2(TREE_NUM),
    parameter int unsigned QDEPTH        = 8,
    parameter int unsigned QAW           = $clog2(QDEPTH),
    parameter int unsigned BACKOFF_CYC   = 4,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [TREE_NUM_BITS-1:0] i_cmd_tree_id,
    input  logic                     i_cmd_is_pop,
    input  logic [MTW+PTW-1:0]       i_cmd_data,
    output logic [TREE_NUM_BITS-1:0] o_tree_id,
    output logic                     o_push,
    output logic [MTW+PTW-1:0]       o_push_data,
    output logic                     o_pop,
    input  logic                     i_task_fail,
    output logic [CNT_W-1:0]         o_issue_cnt,
    output logic [CNT_W-1:0]         o_fail_cnt,
    output logic [CNT_W-1:0]         o_drop_cnt,
    output logic                     o_busy
);
    localparam int unsigned DW = MTW + PTW;
    localparam int unsigned CW = QAW + 1;
    localparam int unsigned RW = $clog2(MAX_RETRY + 1);
    localparam int unsigned BW = $clog2(BACKOFF_CYC + 1);
    localparam logic [CW-1:0] QFull       = CW'(QDEPTH);
    localparam logic [RW-1:0] RetryLast   = RW'(MAX_RETRY - 1);
    localparam logic [BW-1:0] BackoffLoad = BW'(BACKOFF_CYC);

    typedef struct packed {
        logic [TREE_NUM_BITS-1:0] tree_id;
        logic                     is_pop;
        logic [DW-1:0]            data;
    } cmd_t;

    typedef enum logic [1:0] {StIdle, StIssue, StBackoff} state_e;

    cmd_t             mem_q [QDEPTH];
    logic [QAW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    state_e           state_q, state_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [BW-1:0]    backoff_q, backoff_d;
    logic [CNT_W-1:0] issue_cnt_q, fail_cnt_q, drop_cnt_q;
    logic             enq, deq, issue_inc, fail_inc, drop_inc;
    cmd_t             head;

    // Ready comes only from the registered count, so a same-cycle dequeue never frees a slot.
    assign o_cmd_ready = (count_q != QFull);
    assign enq         = i_cmd_valid && o_cmd_ready;
    assign head        = mem_q[rd_ptr_q];
    assign o_busy      = (count_q != '0) || (state_q != StIdle);
    assign o_issue_cnt = issue_cnt_q;
    assign o_fail_cnt  = fail_cnt_q;
    assign o_drop_cnt  = drop_cnt_q;

    always_comb begin
        count_d = count_q;
        if (enq && !deq) begin
            count_d = count_q + CW'(1);
        end else if (!enq && deq) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + QAW'(1);
            if (deq) rd_ptr_q <= rd_ptr_q + QAW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= cmd_t'{tree_id: i_cmd_tree_id, is_pop: i_cmd_is_pop,
                                      data: i_cmd_data};
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q   <= StIdle;
            retry_q   <= '0;
            backoff_q <= '0;
        end else begin
            state_q   <= state_d;
            retry_q   <= retry_d;
            backoff_q <= backoff_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        backoff_d = backoff_q;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) state_d = StIssue;
            end
            StIssue: begin
                // Success and final-failure drop both retire the head.
                if (!i_task_fail || retry_q == RetryLast) begin
                    retry_d = '0;
                    state_d = (count_q == CW'(1)) ? StIdle : StIssue;
                end else begin
                    retry_d   = retry_q + RW'(1);
                    backoff_d = BackoffLoad;
                    state_d   = StBackoff;
                end
            end
            StBackoff: begin
                backoff_d = backoff_q - BW'(1);
                if (backoff_q == BW'(1)) state_d = StIssue;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_tree_id   = '0;
        o_push      = 1'b0;
        o_pop       = 1'b0;
        o_push_data = '0;
        deq         = 1'b0;
        issue_inc   = 1'b0;
        fail_inc    = 1'b0;
        drop_inc    = 1'b0;
        if (state_q == StIssue) begin
            o_tree_id   = head.tree_id;
            o_push      = !head.is_pop;
            o_pop       = head.is_pop;
            o_push_data = head.is_pop ? '0 : head.data;
            if (!i_task_fail) begin
                deq       = 1'b1;
                issue_inc = 1'b1;
            end else begin
                fail_inc = 1'b1;
                if (retry_q == RetryLast) begin
                    drop_inc = 1'b1;
                    deq      = 1'b1;
                end
            end
        end
    end

    // Statistics saturate at all-ones.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            issue_cnt_q <= '0;
            fail_cnt_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (issue_inc && issue_cnt_q != '1) issue_cnt_q <= issue_cnt_q + CNT_W'(1);
            if (fail_inc && fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + CNT_W'(1);
            if (drop_inc && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pifo_cmd_scheduler.sv
// Bench for pifo_cmd_scheduler: directed vector table, hand-written corner sequences, and a
// randomized run scored against a transaction-level queue model.
module tb_pifo_cmd_scheduler;
    localparam int unsigned QDEPTH      = 8;
    localparam int unsigned BACKOFF_CYC = 4;
    localparam int unsigned MAX_RETRY   = 3;

    logic        clk = 1'b0;
    logic        i_arst_n;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [1:0]  i_cmd_tree_id;
    logic        i_cmd_is_pop;
    logic [15:0] i_cmd_data;
    logic [1:0]  o_tree_id;
    logic        o_push;
    logic [15:0] o_push_data;
    logic        o_pop;
    logic        i_task_fail;
    logic [15:0] o_issue_cnt, o_fail_cnt, o_drop_cnt;
    logic        o_busy;

    always #5 clk = ~clk;

    pifo_cmd_scheduler #(
        .PTW(16), .MTW(0), .TREE_NUM(4), .QDEPTH(QDEPTH), .BACKOFF_CYC(BACKOFF_CYC),
        .MAX_RETRY(MAX_RETRY), .CNT_W(16)
    ) dut (
        .i_clk(clk), .i_arst_n(i_arst_n), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_tree_id(i_cmd_tree_id), .i_cmd_is_pop(i_cmd_is_pop), .i_cmd_data(i_cmd_data),
        .o_tree_id(o_tree_id), .o_push(o_push), .o_push_data(o_push_data), .o_pop(o_pop),
        .i_task_fail(i_task_fail), .o_issue_cnt(o_issue_cnt), .o_fail_cnt(o_fail_cnt),
        .o_drop_cnt(o_drop_cnt), .o_busy(o_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Directed per-cycle vectors: inputs for the cycle and the outputs expected in it.
    typedef struct {
        logic v; logic [1:0] t; logic p; logic [15:0] d; logic f;
        logic rdy; logic ps; logic pp; logic [1:0] ot; logic [15:0] od; logic bz;
        int ic; int fc; int dc;
    } vec_t;
    vec_t tbl[$];

    task automatic row(input logic v, input logic [1:0] t, input logic p, input logic [15:0] d,
                       input logic f, input logic rdy, input logic ps, input logic pp,
                       input logic [1:0] ot, input logic [15:0] od, input logic bz,
                       input int ic, input int fc, input int dc);
        tbl.push_back(vec_t'{v: v, t: t, p: p, d: d, f: f, rdy: rdy, ps: ps, pp: pp, ot: ot,
                             od: od, bz: bz, ic: ic, fc: fc, dc: dc});
    endtask

    // Transaction-level model: a plain FIFO of accepted commands plus attempt bookkeeping.
    typedef struct { logic [1:0] tree; logic pop; logic [15:0] data; } mcmd_t;
    mcmd_t mq[$];
    int    m_issue, m_fail, m_drop, m_attempts, last_fail_cyc, cyc;
    bit    pend_retry;

    task automatic model_reset();
        mq.delete();
        m_issue = 0; m_fail = 0; m_drop = 0; m_attempts = 0;
        last_fail_cyc = 0; cyc = 0; pend_retry = 0;
    endtask

    task automatic drive(input logic v, input logic [1:0] t, input logic p, input logic [15:0] d,
                         input logic f);
        i_cmd_valid = v; i_cmd_tree_id = t; i_cmd_is_pop = p; i_cmd_data = d; i_task_fail = f;
    endtask

    task automatic apply_reset();
        i_arst_n = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 16'd0, 1'b0);
        repeat (2) @(negedge clk);
        i_arst_n = 1'b1;
        model_reset();
    endtask

    // One cycle, entered and left at a falling edge: check outputs, update model, drive inputs.
    task automatic step(input logic v, input logic [1:0] t, input logic p, input logic [15:0] d,
                        input logic f, output bit acc);
        bit    issuing;
        bit    m_rdy;
        mcmd_t h;
        m_rdy = (mq.size() < QDEPTH);
        chk("ready", 32'(o_cmd_ready), 32'(m_rdy));
        chk("busy", 32'(o_busy), 32'(mq.size() != 0));
        chk("issue_cnt", 32'(o_issue_cnt), 32'(m_issue));
        chk("fail_cnt", 32'(o_fail_cnt), 32'(m_fail));
        chk("drop_cnt", 32'(o_drop_cnt), 32'(m_drop));
        issuing = o_push || o_pop;
        if (issuing) begin
            chk("issue_nonempty", 32'(mq.size() != 0), 32'd1);
            if (mq.size() != 0) begin
                h = mq[0];
                chk("head_tree", 32'(o_tree_id), 32'(h.tree));
                chk("head_push", 32'(o_push), 32'(!h.pop));
                chk("head_pop", 32'(o_pop), 32'(h.pop));
                chk("head_data", 32'(o_push_data), h.pop ? 32'd0 : 32'(h.data));
                if (pend_retry) chk("retry_gap", 32'(cyc - last_fail_cyc), 32'(BACKOFF_CYC + 1));
                pend_retry = 0;
                if (f) begin
                    m_fail++;
                    m_attempts++;
                    if (m_attempts == MAX_RETRY) begin
                        m_drop++;
                        void'(mq.pop_front());
                        m_attempts = 0;
                    end else begin
                        pend_retry    = 1;
                        last_fail_cyc = cyc;
                    end
                end else begin
                    m_issue++;
                    void'(mq.pop_front());
                    m_attempts = 0;
                end
            end
        end else begin
            chk("quiet_tree", 32'(o_tree_id), 32'd0);
            chk("quiet_data", 32'(o_push_data), 32'd0);
            if (pend_retry)
                chk("retry_not_late", 32'(cyc - last_fail_cyc < BACKOFF_CYC + 1), 32'd1);
        end
        acc = v && m_rdy;
        if (acc) mq.push_back(mcmd_t'{tree: t, pop: p, data: d});
        drive(v, t, p, d, f);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 300 && mq.size() != 0; k++) step(1'b0, 2'd0, 1'b0, 16'd0, 1'b0, acc);
        chk("drain_empty", 32'(mq.size()), 32'd0);
        repeat (2) step(1'b0, 2'd0, 1'b0, 16'd0, 1'b0, acc);
    endtask

    initial begin
        bit acc;
        int sent;
        i_arst_n = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 16'd0, 1'b0);
        repeat (2) @(negedge clk);
        i_arst_n = 1'b1;

        // Single push; pop failing once; push stuck failing then dropped with a follower queued.
        row(1, 2, 0, 16'h00AB, 0,  1, 0, 0, 0, 16'h0000, 0,  0, 0, 0);
        row(0, 0, 0, 16'h0000, 0,  1, 0, 0, 0, 16'h0000, 1,  0, 0, 0);
        row(0, 0, 0, 16'h0000, 0,  1, 1, 0, 2, 16'h00AB, 1,  0, 0, 0);
        row(0, 0, 0, 16'h0000, 0,  1, 0, 0, 0, 16'h0000, 0,  1, 0, 0);
        row(1, 1, 1, 16'h1234, 0,  1, 0, 0, 0, 16'h0000, 0,  1, 0, 0);
        row(0, 0, 0, 16'h0000, 1,  1, 0, 0, 0, 16'h0000, 1,  1, 0, 0);
        row(0, 0, 0, 16'h0000, 1,  1, 0, 1, 1, 16'h0000, 1,  1, 0, 0);
        for (int i = 0; i < 4; i++) row(0, 0, 0, 16'h0000, 1,  1, 0, 0, 0, 16'h0000, 1,  1, 1, 0);
        row(0, 0, 0, 16'h0000, 0,  1, 0, 1, 1, 16'h0000, 1,  1, 1, 0);
        row(0, 0, 0, 16'h0000, 1,  1, 0, 0, 0, 16'h0000, 0,  2, 1, 0);
        row(1, 3, 0, 16'h0111, 0,  1, 0, 0, 0, 16'h0000, 0,  2, 1, 0);
        row(1, 0, 0, 16'h0222, 0,  1, 0, 0, 0, 16'h0000, 1,  2, 1, 0);
        row(0, 0, 0, 16'h0000, 1,  1, 1, 0, 3, 16'h0111, 1,  2, 1, 0);
        for (int i = 0; i < 4; i++) row(0, 0, 0, 16'h0000, 1,  1, 0, 0, 0, 16'h0000, 1,  2, 2, 0);
        row(0, 0, 0, 16'h0000, 1,  1, 1, 0, 3, 16'h0111, 1,  2, 2, 0);
        for (int i = 0; i < 4; i++) row(0, 0, 0, 16'h0000, 1,  1, 0, 0, 0, 16'h0000, 1,  2, 3, 0);
        row(0, 0, 0, 16'h0000, 1,  1, 1, 0, 3, 16'h0111, 1,  2, 3, 0);
        row(0, 0, 0, 16'h0000, 0,  1, 1, 0, 0, 16'h0222, 1,  2, 4, 1);
        row(0, 0, 0, 16'h0000, 0,  1, 0, 0, 0, 16'h0000, 0,  3, 4, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].t, tbl[i].p, tbl[i].d, tbl[i].f);
            #1;
            chk($sformatf("tbl%0d_ready", i), 32'(o_cmd_ready), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_push", i), 32'(o_push), 32'(tbl[i].ps));
            chk($sformatf("tbl%0d_pop", i), 32'(o_pop), 32'(tbl[i].pp));
            chk($sformatf("tbl%0d_tree", i), 32'(o_tree_id), 32'(tbl[i].ot));
            chk($sformatf("tbl%0d_data", i), 32'(o_push_data), 32'(tbl[i].od));
            chk($sformatf("tbl%0d_busy", i), 32'(o_busy), 32'(tbl[i].bz));
            chk($sformatf("tbl%0d_icnt", i), 32'(o_issue_cnt), 32'(tbl[i].ic));
            chk($sformatf("tbl%0d_fcnt", i), 32'(o_fail_cnt), 32'(tbl[i].fc));
            chk($sformatf("tbl%0d_dcnt", i), 32'(o_drop_cnt), 32'(tbl[i].dc));
            @(posedge clk);
            @(negedge clk);
        end

        // Back-to-back: ten commands, one issued per cycle from cycle 2 onward.
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            chk("b2b_ready", 32'(o_cmd_ready), 32'd1);
            if (k >= 2) chk("b2b_rate", 32'(o_push), 32'd1);
            step(k < 10, 2'(k % 4), 1'b0, 16'(16'h0100 + k), 1'b0, acc);
        end
        drain();
        chk("b2b_issue_cnt", 32'(o_issue_cnt), 32'd10);

        // Stall: head fails while twelve pushes are offered; queue fills and holds order.
        apply_reset();
        sent = 0;
        for (int k = 0; k < 60; k++) begin
            if (k == 10) chk("stall_ready_low", 32'(o_cmd_ready), 32'd0);
            step(sent < 12, 2'(sent % 4), 1'b0, 16'(16'h0300 + sent), k < 12, acc);
            if (acc) sent++;
        end
        chk("stall_all_sent", 32'(sent), 32'd12);
        drain();
        chk("stall_issue_cnt", 32'(o_issue_cnt), 32'd12);
        chk("stall_drop_cnt", 32'(o_drop_cnt), 32'd0);

        // Reset during backoff with three commands queued.
        apply_reset();
        step(1'b1, 2'd1, 1'b0, 16'h0AAA, 1'b0, acc);
        step(1'b1, 2'd2, 1'b1, 16'h0BBB, 1'b0, acc);
        step(1'b1, 2'd3, 1'b0, 16'h0CCC, 1'b1, acc);
        chk("bo_busy", 32'(o_busy), 32'd1);
        chk("bo_ready", 32'(o_cmd_ready), 32'd1);
        i_arst_n = 1'b0;
        #1;
        chk("rst_push", 32'(o_push), 32'd0);
        chk("rst_pop", 32'(o_pop), 32'd0);
        chk("rst_tree", 32'(o_tree_id), 32'd0);
        chk("rst_data", 32'(o_push_data), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_ready", 32'(o_cmd_ready), 32'd1);
        chk("rst_fcnt", 32'(o_fail_cnt), 32'd0);
        chk("rst_icnt", 32'(o_issue_cnt), 32'd0);
        apply_reset();
        repeat (8) step(1'b0, 2'd0, 1'b0, 16'd0, 1'b1, acc);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 99) < 60, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 16'($urandom), $urandom_range(0, 99) < 30, acc);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
